div: RTL

Iterative 32-bit radix-2 restoring divider for the MIPS `DIV`/`DIVU` instructions. It sits beside the execute stage. It takes operands when the execute stage issues a divide. It returns a 64-bit {remainder, quotient} result, which the execute stage forwards down the pipeline as the HI/LO write data. While a divide runs, the execute stage stalls the pipeline using `ready_o`.

---
 rtl/div_if.sv | 20 ++
 rtl/div.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/div_if.sv
// rtl/div_if.sv - divider issue/result bundle between execute stage (master) and divider (slave)
interface div_if #(parameter int WIDTH = 32);
    logic               start_i;
    logic               annul_i;
    logic               signed_div_i;
    logic [WIDTH-1:0]   opdata1_i;
    logic [WIDTH-1:0]   opdata2_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;

    modport master (
        output start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
        input  result_o, ready_o
    );

    modport slave (
        input  start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div.sv
// rtl/div.sv - iterative radix-2 restoring divider returning {remainder, quotient}
// Signed DIV support (magnitude entry, sign-corrected exit) is built only when DIV_SIGNED_EN is defined.
module div #(
    parameter int WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    div_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     dvd_q, dvd_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 ready_q, ready_d;

    logic [WIDTH:0]       shifted;
    logic [WIDTH-1:0]     diff;
    logic                 fits;
    logic [WIDTH-1:0]     mag1, mag2;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

`ifdef DIV_SIGNED_EN
    logic neg_quo_q, neg_quo_d;
    logic neg_rem_q, neg_rem_d;
    logic neg1, neg2;

    always_comb begin
        neg1    = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
        neg2    = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
        mag1    = neg1 ? ({WIDTH{1'b0}} - bus.opdata1_i) : bus.opdata1_i;
        mag2    = neg2 ? ({WIDTH{1'b0}} - bus.opdata2_i) : bus.opdata2_i;
        quo_fix = neg_quo_q ? ({WIDTH{1'b0}} - dvd_q) : dvd_q;
        rem_fix = neg_rem_q ? ({WIDTH{1'b0}} - rem_q) : rem_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end
`else
    always_comb begin
        mag1    = bus.opdata1_i;
        mag2    = bus.opdata2_i;
        quo_fix = dvd_q;
        rem_fix = rem_q;
    end
`endif

    // One restoring step: dividend MSB shifts into the remainder, trial-subtract the divisor.
    // A fitting difference is always below the divisor, so WIDTH bits hold it.
    always_comb begin
        shifted = {rem_q, dvd_q[WIDTH-1]};
        fits    = (shifted >= {1'b0, dvs_q});
        diff    = shifted[WIDTH-1:0] - dvs_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        result_d = result_q;
`ifdef DIV_SIGNED_EN
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
`endif
        case (state_q)
            FREE: begin
                if (bus.start_i && !bus.annul_i) begin
                    if (bus.opdata2_i == '0) begin
                        state_d = BYZERO;
                    end else begin
                        dvd_d   = mag1;
                        dvs_d   = mag2;
                        rem_d   = '0;
                        cnt_d   = '0;
`ifdef DIV_SIGNED_EN
                        neg_quo_d = neg1 ^ neg2;
                        neg_rem_d = neg1;
`endif
                        state_d = ON;
                    end
                end
            end
            BYZERO: begin
                if (bus.annul_i) begin
                    state_d = FREE;
                end else begin
                    result_d = '0;
                    state_d  = END;
                end
            end
            ON: begin
                if (bus.annul_i) begin
                    state_d = FREE;
                end else if (cnt_q == CW'(WIDTH)) begin
                    result_d = {rem_fix, quo_fix};
                    state_d  = END;
                end else begin
                    rem_d = fits ? diff : shifted[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], fits};
                    cnt_d = cnt_q + 1'b1;
                end
            end
            END: begin
                // Holding in END while start stays high keeps a stalled execute stage from re-issuing.
                if (bus.annul_i || !bus.start_i) begin
                    state_d = FREE;
                end
            end
            default: state_d = FREE;
        endcase
        ready_d = (state_d == END);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= FREE;
            cnt_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;
endmodule
